reg32_rd_port: RTL

//  - Read-side responder for the 16 x 32-bit address-decoded register bank.
//  - Accepts single or burst read requests over a valid/ready channel.
//  - Returns register snapshots on a registered valid/ready response channel with a last-beat flag.
//  - Sits between the bank outputs (flattened onto reg_bus) and the host/bus read path.

---
 rtl/reg32_rd_port_if.sv | 36 +++
 rtl/reg32_rd_port.sv | 132 +++++++++++++
 2 files changed

// File: rtl/reg32_rd_port_if.sv
// Request/response channel bundle for the register-bank read port.
// rsp_parity exists only when RD_PARITY_EN is defined.
interface reg32_rd_port_if #(
    parameter int DATA_W = 32
);
    logic              rd_req_valid;
    logic              rd_req_ready;
    logic [3:0]        rd_addr;
    logic [3:0]        rd_len;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_last;
    logic              rsp_err;
`ifdef RD_PARITY_EN
    logic              rsp_parity;

    modport master (
        output rd_req_valid, rd_addr, rd_len, rsp_ready,
        input  rd_req_ready, rsp_valid, rsp_data, rsp_last, rsp_err, rsp_parity
    );
    modport slave (
        input  rd_req_valid, rd_addr, rd_len, rsp_ready,
        output rd_req_ready, rsp_valid, rsp_data, rsp_last, rsp_err, rsp_parity
    );
`else
    modport master (
        output rd_req_valid, rd_addr, rd_len, rsp_ready,
        input  rd_req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
    );
    modport slave (
        input  rd_req_valid, rd_addr, rd_len, rsp_ready,
        output rd_req_ready, rsp_valid, rsp_data, rsp_last, rsp_err
    );
`endif
endinterface

// File: rtl/reg32_rd_port.sv
// Read-side responder for the 16 x DATA_W register bank: single/burst reads with a
// registered response slot. Optional feature macro: RD_PARITY_EN (adds rsp_parity).
module reg32_rd_port #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [16*DATA_W-1:0] reg_bus,
    reg32_rd_port_if.slave       rd
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cur_addr_q, cur_addr_d;
    logic [3:0]        remain_q, remain_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              rsp_last_q, rsp_last_d;
    logic              rsp_err_q, rsp_err_d;

    logic              slot_free;
    logic              beat_err;
    logic [DATA_W-1:0] beat_data;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    assign slot_free = !rsp_valid_q || rd.rsp_ready;
    assign beat_err  = ({28'd0, cur_addr_q} >= 32'(NUM_REGS));

    // Error beats return zero rather than whatever sits above NUM_REGS on the bus.
    always_comb begin
        beat_data = '0;
        for (int i = 0; i < 16; i++) begin
            if (cur_addr_q == 4'(i) && !beat_err) begin
                beat_data = reg_bus[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remain_d    = remain_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = rsp_last_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (rsp_valid_q && rd.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_last_d  = 1'b0;
                end
                if (rd.rd_req_valid) begin
                    cur_addr_d = rd.rd_addr;
                    remain_d   = rd.rd_len;
                    state_d    = BURST;
                end
            end
            BURST: begin
                if (slot_free) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = beat_data;
                    rsp_err_d   = beat_err;
                    rsp_last_d  = (remain_q == 4'd0);
                    cur_addr_d  = cur_addr_q + 4'd1;
                    remain_d    = remain_q - 4'd1;
                    if (remain_q == 4'd0) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remain_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remain_q    <= remain_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef RD_PARITY_EN
    logic rsp_parity_q, rsp_parity_d;

    // Parity follows the loaded data, so error beats (data 0) carry parity 0.
    always_comb begin
        rsp_parity_d = rsp_parity_q;
        if (state_q == BURST && slot_free) begin
            rsp_parity_d = even_parity(beat_data);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_parity_q <= 1'b0;
        end else begin
            rsp_parity_q <= rsp_parity_d;
        end
    end

    assign rd.rsp_parity = rsp_parity_q;
`endif

    assign rd.rd_req_ready = (state_q == IDLE);
    assign rd.rsp_valid    = rsp_valid_q;
    assign rd.rsp_data     = rsp_data_q;
    assign rd.rsp_last     = rsp_last_q;
    assign rd.rsp_err      = rsp_err_q;

endmodule
